// File: rtl/branch_ctlr.sv
// Branch decision unit for the single-cycle RV32I core.
// Turns the decoded branch type plus the ALU zero/sign flags of rs1-rs2 into
// pc_src, and keeps diagnostic counters of branches seen and taken along with
// a sticky flag for the reserved branch encoding.
module branch_ctlr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       branch_in,
  input  logic             zero_flag,
  input  logic             sign_flag,
  output logic             pc_src,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             illegal
);

  // Branch type encoding produced by the main decoder
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_JAL  = 3'b101,
    BR_JALR = 3'b110,
    BR_RSVD = 3'b111
  } branch_t;

  branch_t branch_type;
  logic    decode_take;
  logic    is_cond;
  logic    is_rsvd;

  assign branch_type = branch_t'(branch_in);

  // Combinational decode: the flags only matter for the conditional branches,
  // and any encoding without a meaningful arm falls back to "not taken"
  always_comb begin
    decode_take = 1'b0;
    is_cond     = 1'b0;
    is_rsvd     = 1'b0;
    case (branch_type)
      BR_BEQ:  begin decode_take = zero_flag;  is_cond = 1'b1; end
      BR_BNE:  begin decode_take = ~zero_flag; is_cond = 1'b1; end
      BR_BLT:  begin decode_take = sign_flag;  is_cond = 1'b1; end
      BR_BGE:  begin decode_take = ~sign_flag; is_cond = 1'b1; end
      BR_JAL:  decode_take = 1'b1;
      BR_JALR: decode_take = 1'b1;
      BR_RSVD: is_rsvd = 1'b1;
      default: decode_take = 1'b0;
    endcase
  end

  // Reset holds the PC on the sequential path no matter what the decoder says
  assign pc_src = decode_take & ~rst;

  // Diagnostic counters and sticky illegal flag; a reset edge discards the
  // sample presented in that same cycle rather than counting it
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
      illegal    <= 1'b0;
    end else begin
      if (is_cond) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (pc_src) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
      if (is_rsvd) begin
        illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctlr.sv
// Self-checking bench for branch_ctlr: a truth-table sweep, hand-written
// multi-cycle sequences and randomized operand comparisons checked against a
// reference model that reasons about rs1/rs2 directly.
module tb_branch_ctlr;

  logic        clk;
  logic        rst;
  logic [2:0]  branch_in;
  logic        zero_flag;
  logic        sign_flag;
  logic        pc_src;
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;
  logic        illegal;
  logic        pc_src_n;
  logic [3:0]  branch_cnt_n;
  logic [3:0]  taken_cnt_n;
  logic        illegal_n;

  int total = 0;
  int bad   = 0;

  // Reference model state (32-bit counters; the narrow instance sees the low 4 bits)
  logic [31:0] m_br;
  logic [31:0] m_tk;
  logic        m_ill;

  typedef struct {
    logic [2:0] code;
    logic       z;
    logic       s;
    logic       exp_pc;
  } vec_t;

  vec_t vecs[32];

  branch_ctlr #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .branch_in(branch_in), .zero_flag(zero_flag),
    .sign_flag(sign_flag), .pc_src(pc_src), .branch_cnt(branch_cnt),
    .taken_cnt(taken_cnt), .illegal(illegal)
  );

  branch_ctlr #(.CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .branch_in(branch_in), .zero_flag(zero_flag),
    .sign_flag(sign_flag), .pc_src(pc_src_n), .branch_cnt(branch_cnt_n),
    .taken_cnt(taken_cnt_n), .illegal(illegal_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle, check the combinational decision, then check state after the edge
  task automatic applyStimulus(input logic [2:0] code, input logic z, input logic s,
                               input logic r, input logic exp_pc, input string name);
    @(negedge clk);
    branch_in = code;
    zero_flag = z;
    sign_flag = s;
    rst       = r;
    #1;
    checkOutput({name, " pc_src"}, {31'd0, pc_src}, {31'd0, exp_pc});
    checkOutput({name, " pc_src_n"}, {31'd0, pc_src_n}, {31'd0, exp_pc});
    @(posedge clk);
    #1;
    if (r) begin
      m_br  = 0;
      m_tk  = 0;
      m_ill = 1'b0;
    end else begin
      if (code >= 3'd1 && code <= 3'd4) m_br = m_br + 1;
      if (exp_pc) m_tk = m_tk + 1;
      if (code == 3'd7) m_ill = 1'b1;
    end
    checkOutput({name, " branch_cnt"}, branch_cnt, m_br);
    checkOutput({name, " taken_cnt"}, taken_cnt, m_tk);
    checkOutput({name, " illegal"}, {31'd0, illegal}, {31'd0, m_ill});
    checkOutput({name, " branch_cnt_n"}, {28'd0, branch_cnt_n}, {28'd0, m_br[3:0]});
    checkOutput({name, " taken_cnt_n"}, {28'd0, taken_cnt_n}, {28'd0, m_tk[3:0]});
    checkOutput({name, " illegal_n"}, {31'd0, illegal_n}, {31'd0, m_ill});
  endtask

  // Outcome from the operands themselves, as the ISA defines the branch
  function automatic logic refTake(input logic [2:0] code, input int a, input int b);
    case (code)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return a < b;
      3'd4:    return a >= b;
      3'd5:    return 1'b1;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [3:0] pat[8];
    m_br  = 0;
    m_tk  = 0;
    m_ill = 1'b0;
    rst = 1'b1;
    branch_in = 3'b101;
    zero_flag = 1'b0;
    sign_flag = 1'b0;

    // Expected pc_src per code, bit index = {zero, sign}
    pat[0] = 4'b0000;
    pat[1] = 4'b1100;
    pat[2] = 4'b0011;
    pat[3] = 4'b1010;
    pat[4] = 4'b0101;
    pat[5] = 4'b1111;
    pat[6] = 4'b1111;
    pat[7] = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) begin
        vecs[c*4+i].code   = 3'(c);
        vecs[c*4+i].z      = i[1];
        vecs[c*4+i].s      = i[0];
        vecs[c*4+i].exp_pc = pat[c][i];
      end
    end

    // Reset with a JAL presented: no jump, everything cleared
    applyStimulus(3'b101, 1'b0, 1'b0, 1'b1, 1'b0, "reset_jal");
    checkOutput("reset branch_cnt", branch_cnt, 32'd0);
    checkOutput("reset taken_cnt", taken_cnt, 32'd0);
    checkOutput("reset illegal", {31'd0, illegal}, 32'd0);

    // Full truth table sweep
    for (int i = 0; i < 32; i++) begin
      applyStimulus(vecs[i].code, vecs[i].z, vecs[i].s, 1'b0, vecs[i].exp_pc,
                    $sformatf("table c%0d z%0d s%0d", vecs[i].code, vecs[i].z, vecs[i].s));
    end

    // 4 taken BEQs then 3 untaken BNEs
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, "seq1_rst");
    for (int i = 0; i < 4; i++) applyStimulus(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, "seq1_beq");
    for (int i = 0; i < 3; i++) applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, "seq1_bne");
    checkOutput("seq1 branch_cnt", branch_cnt, 32'd7);
    checkOutput("seq1 taken_cnt", taken_cnt, 32'd4);

    // Sticky illegal flag survives legal traffic and clears only on reset
    applyStimulus(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, "ill_set");
    checkOutput("ill set", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "ill_hold");
    checkOutput("ill held", {31'd0, illegal}, 32'd1);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, "ill_rst");
    checkOutput("ill cleared", {31'd0, illegal}, 32'd0);

    // 17 jumps wrap the 4-bit taken counter to 1
    for (int i = 0; i < 17; i++) applyStimulus(3'b101, 1'b0, 1'b0, 1'b0, 1'b1, "wrap_jal");
    checkOutput("wrap taken_cnt_n", {28'd0, taken_cnt_n}, 32'd1);
    checkOutput("wrap branch_cnt_n", {28'd0, branch_cnt_n}, 32'd0);
    checkOutput("wrap taken_cnt", taken_cnt, 32'd17);

    // Reset in the middle of a taken-BGE stream, then counting restarts from 0
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, "mid_pre");
    for (int i = 0; i < 3; i++) applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 1'b1, "mid_bge");
    applyStimulus(3'b100, 1'b0, 1'b0, 1'b1, 1'b0, "mid_rst");
    checkOutput("mid rst branch_cnt", branch_cnt, 32'd0);
    checkOutput("mid rst taken_cnt", taken_cnt, 32'd0);
    applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 1'b1, "mid_resume");
    checkOutput("mid resume branch_cnt", branch_cnt, 32'd1);
    checkOutput("mid resume taken_cnt", taken_cnt, 32'd1);

    // Randomized operands: flags derived from rs1/rs2, outcome from the operands
    for (int i = 0; i < 300; i++) begin
      int a, b;
      logic [2:0] code;
      logic r, exp;
      a    = int'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? a : int'($urandom);
      code = 3'($urandom_range(0, 7));
      r    = ($urandom_range(0, 19) == 0);
      exp  = r ? 1'b0 : refTake(code, a, b);
      applyStimulus(code, a == b, a < b, r, exp, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
